// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: widths, the MEM-stage access states and the
// MEM/WB register payload with its bubble value.
package pipe_pkg;

    localparam int PIPE_DATA_W = 32;
    localparam int PIPE_ADDR_W = 30;
    localparam int PIPE_REG_W  = 5;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    typedef struct packed {
        logic                   regwrite;
        logic                   memtoreg;
        logic                   isjal;
        logic [PIPE_REG_W-1:0]  rd_addr;
        logic [PIPE_DATA_W-1:0] alu_res;
        logic [PIPE_DATA_W-1:0] mem_data;
        logic [PIPE_DATA_W-1:0] pc_plus4;
    } mem_wb_t;

    // An all-zero entry is a NOP for write-back: no register write, no JAL link.
    localparam mem_wb_t BUBBLE = '0;

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register: async-reset, load-enabled, with a bubble select
// that squashes the incoming entry to a NOP.
module mem_wb_reg
    import pipe_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  logic    load,
    input  logic    bubble,
    input  mem_wb_t d,
    output mem_wb_t q
);

    // Capture the next write-back entry (or a NOP) whenever loading.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= BUBBLE;
        end else if (load) begin
            q <= bubble ? BUBBLE : d;
        end
    end

endmodule

// File: rtl/mem_stage_dport.sv
// MEM-stage data port: turns EX/MEM MemRead/MemWrite into data-cache requests,
// stalls the front of the pipeline until the cache answers, and owns MEM/WB.
// Optional build macro MEM_STAGE_PERF_EN adds stall / memory-op counters.
module mem_stage_dport
    import pipe_pkg::*;
#(
    parameter int DATA_W = PIPE_DATA_W,
    parameter int ADDR_W = PIPE_ADDR_W,
    parameter int REG_W  = PIPE_REG_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] mem_alu_res,
    input  logic [DATA_W-1:0] mem_rt,
    input  logic [REG_W-1:0]  mem_rd_addr,
    input  logic [DATA_W-1:0] mem_pc_plus4,
    input  logic              mem_regwrite,
    input  logic              mem_memtoreg,
    input  logic              mem_memread,
    input  logic              mem_memwrite,
    input  logic              mem_isjal,
    output logic              dc_read,
    output logic              dc_write,
    output logic [ADDR_W-1:0] dc_addr,
    output logic [DATA_W-1:0] dc_wdata,
    input  logic [DATA_W-1:0] dc_rdata,
    input  logic              dc_ready,
    output logic              stall,
    output logic              wb_regwrite,
    output logic              wb_memtoreg,
    output logic              wb_isjal,
    output logic [REG_W-1:0]  wb_rd_addr,
    output logic [DATA_W-1:0] wb_alu_res,
    output logic [DATA_W-1:0] wb_mem_data,
    output logic [DATA_W-1:0] wb_pc_plus4
`ifdef MEM_STAGE_PERF_EN
    ,
    output logic [31:0]       perf_stall_cnt,
    output logic [31:0]       perf_memop_cnt
`endif
);

    state_t            state;
    state_t            state_next;
    logic              mem_op;
    logic              is_read;
    logic              is_write;
    logic              wb_bubble;
    logic [DATA_W-1:0] rdata_buf;
    mem_wb_t           wb_d;
    mem_wb_t           wb_q;
    logic              addr_unused;

    // Word accesses only: the byte offset never reaches the cache.
    assign addr_unused = ^mem_alu_res[1:0];

    // A store takes priority when both MemRead and MemWrite are set.
    assign mem_op   = mem_memread | mem_memwrite;
    assign is_write = mem_memwrite;
    assign is_read  = mem_memread & ~mem_memwrite;

    // Access state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state, stall and MEM/WB bubble select. EX/MEM is frozen while
    // stalled, so DONE still sees the instruction that started the access.
    always_comb begin
        state_next = state;
        stall      = 1'b0;
        wb_bubble  = 1'b0;
        case (state)
            IDLE: begin
                if (mem_op) begin
                    stall      = 1'b1;
                    wb_bubble  = 1'b1;
                    state_next = ACCESS;
                end
            end
            ACCESS: begin
                stall     = 1'b1;
                wb_bubble = 1'b1;
                if (dc_ready) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Cache request: launched on entry to ACCESS, held until the response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dc_read  <= 1'b0;
            dc_write <= 1'b0;
            dc_addr  <= '0;
            dc_wdata <= '0;
        end else if (state == IDLE && mem_op) begin
            dc_read  <= is_read;
            dc_write <= is_write;
            dc_addr  <= mem_alu_res[ADDR_W+1:2];
            dc_wdata <= mem_rt;
        end else if (state == ACCESS && dc_ready) begin
            dc_read  <= 1'b0;
            dc_write <= 1'b0;
        end
    end

    // Hold the cache read data until the instruction commits in DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_buf <= '0;
        end else if (state == ACCESS && dc_ready) begin
            rdata_buf <= dc_rdata;
        end
    end

    // Assemble the write-back entry from the EX/MEM fields.
    always_comb begin
        wb_d          = BUBBLE;
        wb_d.regwrite = mem_regwrite;
        wb_d.memtoreg = mem_memtoreg;
        wb_d.isjal    = mem_isjal;
        wb_d.rd_addr  = mem_rd_addr;
        wb_d.alu_res  = mem_alu_res;
        wb_d.pc_plus4 = mem_pc_plus4;
        wb_d.mem_data = (state == DONE && is_read) ? rdata_buf : '0;
    end

    mem_wb_reg u_mem_wb_reg (
        .clk    (clk),
        .rst    (rst),
        .load   (1'b1),
        .bubble (wb_bubble),
        .d      (wb_d),
        .q      (wb_q)
    );

    assign wb_regwrite = wb_q.regwrite;
    assign wb_memtoreg = wb_q.memtoreg;
    assign wb_isjal    = wb_q.isjal;
    assign wb_rd_addr  = wb_q.rd_addr;
    assign wb_alu_res  = wb_q.alu_res;
    assign wb_mem_data = wb_q.mem_data;
    assign wb_pc_plus4 = wb_q.pc_plus4;

`ifdef MEM_STAGE_PERF_EN
    // Free-running counters of stalled cycles and completed memory ops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_stall_cnt <= '0;
            perf_memop_cnt <= '0;
        end else begin
            if (stall) begin
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            end
            if (state == DONE) begin
                perf_memop_cnt <= perf_memop_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mem_stage_dport.sv
// Testbench for mem_stage_dport: a directed vector table followed by random
// instructions, each checked against expectations derived from the
// instruction and the cache model's response.
module tb_mem_stage_dport;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] mem_alu_res = '0;
    logic [31:0] mem_rt = '0;
    logic [4:0]  mem_rd_addr = '0;
    logic [31:0] mem_pc_plus4 = '0;
    logic        mem_regwrite = 1'b0;
    logic        mem_memtoreg = 1'b0;
    logic        mem_memread = 1'b0;
    logic        mem_memwrite = 1'b0;
    logic        mem_isjal = 1'b0;
    logic        dc_read;
    logic        dc_write;
    logic [29:0] dc_addr;
    logic [31:0] dc_wdata;
    logic [31:0] dc_rdata = '0;
    logic        dc_ready = 1'b0;
    logic        stall;
    logic        wb_regwrite;
    logic        wb_memtoreg;
    logic        wb_isjal;
    logic [4:0]  wb_rd_addr;
    logic [31:0] wb_alu_res;
    logic [31:0] wb_mem_data;
    logic [31:0] wb_pc_plus4;
`ifdef MEM_STAGE_PERF_EN
    logic [31:0] perf_stall_cnt;
    logic [31:0] perf_memop_cnt;
`endif

    int vectors = 0;
    int miscompares = 0;
    int exp_stall_total = 0;
    int exp_memops = 0;

    mem_stage_dport dut (
        .clk          (clk),
        .rst          (rst),
        .mem_alu_res  (mem_alu_res),
        .mem_rt       (mem_rt),
        .mem_rd_addr  (mem_rd_addr),
        .mem_pc_plus4 (mem_pc_plus4),
        .mem_regwrite (mem_regwrite),
        .mem_memtoreg (mem_memtoreg),
        .mem_memread  (mem_memread),
        .mem_memwrite (mem_memwrite),
        .mem_isjal    (mem_isjal),
        .dc_read      (dc_read),
        .dc_write     (dc_write),
        .dc_addr      (dc_addr),
        .dc_wdata     (dc_wdata),
        .dc_rdata     (dc_rdata),
        .dc_ready     (dc_ready),
        .stall        (stall),
`ifdef MEM_STAGE_PERF_EN
        .perf_stall_cnt (perf_stall_cnt),
        .perf_memop_cnt (perf_memop_cnt),
`endif
        .wb_regwrite  (wb_regwrite),
        .wb_memtoreg  (wb_memtoreg),
        .wb_isjal     (wb_isjal),
        .wb_rd_addr   (wb_rd_addr),
        .wb_alu_res   (wb_alu_res),
        .wb_mem_data  (wb_mem_data),
        .wb_pc_plus4  (wb_pc_plus4)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required $finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [31:0] alu;
        logic [31:0] rt;
        logic [31:0] pc4;
        logic [4:0]  rd;
        logic        rw;
        logic        m2r;
        logic        mr;
        logic        mw;
        logic        jal;
        int          dly;
        logic [31:0] rdata;
        logic        noise;
        logic [29:0] e_addr;
        logic        e_rd;
        logic        e_wr;
        logic [31:0] e_mem_data;
        int          e_stall;
    } vec_t;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // Reference: a memory op costs one detect cycle plus the cache latency;
    // stores win over loads; reads return the cache word, everything else 0.
    function automatic vec_t model(input vec_t v);
        vec_t r = v;
        r.e_wr       = v.mw;
        r.e_rd       = v.mr && !v.mw;
        r.e_addr     = 30'(v.alu / 4);
        r.e_mem_data = r.e_rd ? v.rdata : 32'd0;
        r.e_stall    = (v.mr || v.mw) ? 1 + v.dly : 0;
        return r;
    endfunction

    function automatic logic [103:0] wb_now();
        return {wb_regwrite, wb_memtoreg, wb_isjal, wb_rd_addr,
                wb_alu_res, wb_mem_data, wb_pc_plus4};
    endfunction

    // Entered and left one time unit after a rising edge.
    task automatic run_vec(input vec_t v);
        int sc = 0;
        mem_alu_res  = v.alu;
        mem_rt       = v.rt;
        mem_pc_plus4 = v.pc4;
        mem_rd_addr  = v.rd;
        mem_regwrite = v.rw;
        mem_memtoreg = v.m2r;
        mem_memread  = v.mr;
        mem_memwrite = v.mw;
        mem_isjal    = v.jal;
        dc_ready     = v.noise;
        dc_rdata     = $urandom();
        @(negedge clk);
        if (stall) sc++;
        check("idle_stall", 128'(stall), 128'(v.mr || v.mw));
        check("idle_noreq", 128'({dc_read, dc_write}), 128'(0));
        if (v.mr || v.mw) begin
            for (int i = 0; i < v.dly; i++) begin
                @(posedge clk);
                #1;
                dc_ready = (i == v.dly - 1);
                dc_rdata = (i == v.dly - 1) ? v.rdata : $urandom();
                @(negedge clk);
                if (stall) sc++;
                check("access_stall", 128'(stall), 128'(1));
                check("access_req", 128'({dc_read, dc_write, dc_addr, dc_wdata}),
                      128'({v.e_rd, v.e_wr, v.e_addr, v.rt}));
                check("access_bubble", 128'(wb_now()), 128'(0));
            end
            @(posedge clk);
            #1;
            dc_ready = v.noise;
            dc_rdata = $urandom();
            @(negedge clk);
            check("done_stall", 128'(stall), 128'(0));
            check("done_noreq", 128'({dc_read, dc_write}), 128'(0));
        end
        @(posedge clk);
        #1;
        dc_ready = 1'b0;
        check("stall_cycles", 128'(sc), 128'(v.e_stall));
        check("commit", 128'(wb_now()),
              128'({v.rw, v.m2r, v.jal, v.rd, v.alu, v.e_mem_data, v.pc4}));
        exp_stall_total += v.e_stall;
        if (v.mr || v.mw) exp_memops++;
    endtask

    task automatic check_perf();
`ifdef MEM_STAGE_PERF_EN
        check("perf_stall_cnt", 128'(perf_stall_cnt), 128'(exp_stall_total));
        check("perf_memop_cnt", 128'(perf_memop_cnt), 128'(exp_memops));
`endif
    endtask

    vec_t tbl[8];
    vec_t v;

    initial begin
        //           alu           rt            pc4           rd  rw m2r mr mw jal dly rdata         noise e_addr       e_rd e_wr e_mem_data    e_stall
        tbl[0] = '{32'h0000_1234, 32'h0,        32'h0000_0040, 5,  1, 0,  0, 0, 0,  0, 32'h0,        0,    30'h0,       0,   0,   32'h0,        0};
        tbl[1] = '{32'h0000_0100, 32'h0,        32'h0000_0044, 8,  1, 1,  1, 0, 0,  1, 32'hDEADBEEF, 0,    30'h40,      1,   0,   32'hDEADBEEF, 2};
        tbl[2] = '{32'h0000_0020, 32'h0000_CAFE,32'h0000_0048, 0,  0, 0,  0, 1, 0,  4, 32'h0,        0,    30'h8,       0,   1,   32'h0,        5};
        tbl[3] = '{32'h0000_0103, 32'h0,        32'h0000_004C, 9,  1, 1,  1, 0, 0,  2, 32'h1357_9BDF, 1,    30'h40,      1,   0,   32'h1357_9BDF, 3};
        tbl[4] = '{32'hFFFF_FFFC, 32'h8765_4321,32'h0000_0050, 0,  0, 0,  0, 1, 0,  1, 32'h5555_5555, 1,    30'h3FFF_FFFF,0,  1,   32'h0,        2};
        tbl[5] = '{32'h0000_0200, 32'hA5A5_A5A5,32'h0000_0054, 7,  1, 1,  1, 1, 0,  3, 32'h1111_1111, 0,    30'h80,      0,   1,   32'h0,        4};
        tbl[6] = '{32'h0000_0000, 32'h0,        32'h0000_005C, 31, 1, 0,  0, 0, 1,  0, 32'h0,        1,    30'h0,       0,   0,   32'h0,        0};
        tbl[7] = '{32'hFFFF_FFFF, 32'h0,        32'hFFFF_FFFF, 1,  1, 0,  0, 0, 0,  0, 32'h0,        0,    30'h0,       0,   0,   32'h0,        0};

        // Reset state, held with idle inputs.
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", 128'({dc_read, dc_write, dc_addr, dc_wdata, stall}), 128'(0));
        check("reset_wb", 128'(wb_now()), 128'(0));
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 8; i++) begin
            run_vec(tbl[i]);
            if (i == 2) check_perf();
        end
        check_perf();

        // Reset abandons an in-flight load.
        mem_alu_res  = 32'h0000_0200;
        mem_rd_addr  = 5'd4;
        mem_regwrite = 1'b1;
        mem_memtoreg = 1'b1;
        mem_memread  = 1'b1;
        mem_memwrite = 1'b0;
        mem_isjal    = 1'b0;
        dc_ready     = 1'b0;
        @(posedge clk);
        #1;
        check("rst_pre_req", 128'({dc_read, dc_addr}), 128'({1'b1, 30'h80}));
        #2;
        rst = 1'b1;
        #1;
        check("rst_drop_req", 128'({dc_read, dc_write, dc_addr, dc_wdata}), 128'(0));
        check("rst_drop_wb", 128'(wb_now()), 128'(0));
        mem_memread  = 1'b0;
        mem_memtoreg = 1'b0;
        mem_alu_res  = 32'h0000_0077;
        mem_rd_addr  = 5'd3;
        @(negedge clk);
        rst = 1'b0;
        exp_stall_total = 0;
        exp_memops = 0;
        #1;
        check("rst_idle_stall", 128'(stall), 128'(0));
        @(posedge clk);
        #1;
        check("rst_first_commit", 128'({wb_regwrite, wb_rd_addr, wb_alu_res, wb_mem_data}),
              128'({1'b1, 5'd3, 32'h77, 32'h0}));

        // Random instruction stream.
        for (int i = 0; i < 200; i++) begin
            int kind = $urandom_range(0, 3);
            v.alu   = $urandom();
            v.rt    = $urandom();
            v.pc4   = $urandom();
            v.rd    = 5'($urandom());
            v.rw    = 1'($urandom());
            v.m2r   = 1'($urandom());
            v.jal   = 1'($urandom());
            v.mr    = (kind == 1) || (kind == 3);
            v.mw    = (kind == 2) || (kind == 3 && $urandom_range(0, 1) == 1);
            v.dly   = $urandom_range(1, 5);
            v.rdata = $urandom();
            v.noise = 1'($urandom());
            run_vec(model(v));
        end
        check_perf();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
